occupancy_tracker: RTL
======================

OCCUPANCY_TRACKER -- requirements
Module: occupancy_tracker

Interface
REQ-001 Parameter NCH, default 2: number of gates, each with one sensor pair.
REQ-002 Parameter W, default 8: count width.
REQ-003 Parameter MAX, default 200: capacity; legal range 1..2^W-1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 a  in  NCH  outer sensor per gate, level, pre-synchronised to clk.
REQ-007 b  in  NCH  inner sensor per gate, level, pre-synchronised to clk.
REQ-008 count  out  W  current occupancy, registered.
REQ-009 full  out  1  registered, high when count==MAX.
REQ-010 empty  out  1  registered, high when count==0.
REQ-011 enter_tick  out  NCH  one-cycle pulse per completed entry, per gate.
REQ-012 exit_tick  out  NCH  one-cycle pulse per completed exit, per gate.
REQ-013 err  out  1  one-cycle pulse when a net change was clipped (saturating build) or wrapped (wrap build).

Function
REQ-014 Each gate SHALL run an independent direction FSM on the pair {a,b}.
- States: IDLE, E1, E2, E3, X1, X2, X3.
REQ-015 Entry path SHALL be IDLE -{10}-> E1 -{11}-> E2 -{01}-> E3 -{00}-> IDLE.
- enter_tick pulses on the E3->IDLE edge.
REQ-016 Exit path SHALL be IDLE -{01}-> X1 -{11}-> X2 -{10}-> X3 -{00}-> IDLE.
- exit_tick pulses on the X3->IDLE edge.
REQ-017 An unchanged sensor pattern SHALL hold the current state.
REQ-018 Any other pattern SHALL abort to IDLE with no tick.
- This covers 00 mid-sequence and reversal, e.g. E2 receiving 10.
- From IDLE, 11 SHALL stay in IDLE.
REQ-019 Ticks SHALL be registered.
- A tick appears in the cycle after the sample that completes the sequence.
REQ-020 count SHALL update one cycle after the ticks.
- Update: count + popcount(enter_tick) - popcount(exit_tick), computed at width W+$clog2(NCH)+1, signed.
REQ-021 Simultaneous entries and exits from any gates in one cycle SHALL be netted before range checking.
- Net zero leaves count unchanged and does not pulse err.
REQ-022 Saturating build: a result above MAX SHALL clamp to MAX, below 0 SHALL clamp to 0, and err SHALL pulse in the same cycle count updates.
REQ-023 full and empty SHALL change in the same cycle as count.

Reset
REQ-024 reset SHALL asynchronously force the following:
- count=0, empty=1, full=0, err=0.
- All ticks 0.
- All FSMs IDLE.
REQ-025 reset asserted mid-sequence SHALL discard the partial sequence; no tick after release.
REQ-026 After reset release, the first tick SHALL be possible no earlier than a full 4-sample sequence.

Configuration
REQ-027 Macro OCC_WRAP_EN.
- Defined: the result SHALL wrap modulo MAX+1 (MAX+1 -> 0, -1 -> MAX) and err SHALL pulse on every wrap.
- Undefined: saturating per REQ-022.

Structure
REQ-028 Shared package occ_pkg SHALL hold the FSM state encoding and the sensor-pattern constants (P00, P01, P10, P11).
REQ-029 Per-gate FSM SHALL be sub-module gate_dir_fsm.
- Ports: clk, reset, a, b, enter_tick, exit_tick.
- Instantiated NCH times in a generate loop.
- Counter, clamp/wrap and flags SHALL reside in occupancy_tracker.

Verification
Bench uses NCH=2, W=8, MAX=3, T=20 ns.
REQ-030 Gate0 {a,b}: 00,10,11,01,00 -> enter_tick[0] pulses once, count 0->1 one cycle later, empty 1->0.
REQ-031 Gate0 exit 00,01,11,10,00 after count=1 -> exit_tick[0] once, count 1->0, empty=1, err=0.
REQ-032 Gate0 aborted 10,11,10,00 -> no tick, count unchanged.
REQ-033 Both gates enter on the same cycle four times from 0.
- Saturating build: count 2, then 3 with err pulse and full=1.
- OCC_WRAP_EN build: count 2, then 0 with err pulse.
REQ-034 Gate0 entry and gate1 exit complete on the same cycle at count=2 -> count stays 2, err=0.
REQ-035 reset pulsed while gate0 is in E2 -> count=0, no tick after release; a following clean entry counts to 1.

Source files
------------

// File: rtl/occ_pkg.sv
// Shared definitions for the occupancy tracker.
// Holds the per-gate direction FSM state encoding and the sensor-pattern constants.
// A pattern is the {a,b} pair: a is the outer sensor and b is the inner sensor.
package occ_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      E1   = 3'd1,
      E2   = 3'd2,
      E3   = 3'd3,
      X1   = 3'd4,
      X2   = 3'd5,
      X3   = 3'd6
   } dir_state_t;

   localparam logic [1:0] P00 = 2'b00;
   localparam logic [1:0] P01 = 2'b01;
   localparam logic [1:0] P10 = 2'b10;
   localparam logic [1:0] P11 = 2'b11;

endpackage

// File: rtl/gate_dir_fsm.sv
// Per-gate direction detector.
// Tracks the {a,b} sensor sequence of one gate.
// An entry is 10,11,01,00 and an exit is 01,11,10,00.
// A repeated pattern holds the current state. Any other pattern aborts to IDLE without a tick.
// The enter and exit ticks are registered one-cycle pulses.
module gate_dir_fsm
   import occ_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic enter_tick,
   output logic exit_tick
);

   dir_state_t state, state_nxt;
   logic       enter_nxt, exit_nxt;
   logic [1:0] pat;

   assign pat = {a, b};

   // State and tick registers; reset discards any partial sequence
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         enter_tick <= 1'b0;
         exit_tick  <= 1'b0;
      end else begin
         state      <= state_nxt;
         enter_tick <= enter_nxt;
         exit_tick  <= exit_nxt;
      end
   end

   // Next-state decode: advance on the expected pattern, hold on repeat, else abort
   always_comb begin
      state_nxt = IDLE;
      enter_nxt = 1'b0;
      exit_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (pat == P10)      state_nxt = E1;
            else if (pat == P01) state_nxt = X1;
            else                 state_nxt = IDLE;
         end
         E1: begin
            if (pat == P10)      state_nxt = E1;
            else if (pat == P11) state_nxt = E2;
         end
         E2: begin
            if (pat == P11)      state_nxt = E2;
            else if (pat == P01) state_nxt = E3;
         end
         E3: begin
            if (pat == P01)      state_nxt = E3;
            else if (pat == P00) enter_nxt = 1'b1;
         end
         X1: begin
            if (pat == P01)      state_nxt = X1;
            else if (pat == P11) state_nxt = X2;
         end
         X2: begin
            if (pat == P11)      state_nxt = X2;
            else if (pat == P10) state_nxt = X3;
         end
         X3: begin
            if (pat == P10)      state_nxt = X3;
            else if (pat == P00) exit_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/occupancy_tracker.sv
// Occupancy tracker: NCH gates, each with an outer/inner sensor pair.
// Per-gate FSMs (gate_dir_fsm) produce registered enter/exit ticks (stage p0).
// One cycle later the ticks are netted into count, which is then range-limited (stage p1).
// The full and empty flags and the err pulse update in the same cycle as count.
// Build option: define OCC_WRAP_EN to wrap the count modulo MAX+1.
// Left undefined, the count saturates at 0 and MAX.
module occupancy_tracker
   import occ_pkg::*;
#(
   parameter int NCH = 2,
   parameter int W   = 8,
   parameter int MAX = 200
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] a,
   input  logic [NCH-1:0] b,
   output logic [W-1:0]   count,
   output logic           full,
   output logic           empty,
   output logic [NCH-1:0] enter_tick,
   output logic [NCH-1:0] exit_tick,
   output logic           err
);

   // Wide enough for count +/- NCH without overflow, plus a sign bit
   localparam int SW = W + $clog2(NCH) + 1;
   localparam logic signed [SW-1:0] MAX_S = SW'(MAX);
   localparam logic signed [SW-1:0] MOD_S = SW'(MAX + 1);

   function automatic logic signed [SW-1:0] popcnt(input logic [NCH-1:0] v);
      logic signed [SW-1:0] acc;
      acc = '0;
      for (int i = 0; i < NCH; i++) acc = acc + {{(SW-1){1'b0}}, v[i]};
      return acc;
   endfunction

   // Returns {err, limited_value}
   function automatic logic [W:0] range_fix(input logic signed [SW-1:0] v);
`ifdef OCC_WRAP_EN
      logic signed [SW-1:0] r;
      r = v % MOD_S;
      if (r[SW-1]) r = r + MOD_S;
      return {(v > MAX_S) || v[SW-1], r[W-1:0]};
`else
      if (v[SW-1])         return {1'b1, {W{1'b0}}};
      else if (v > MAX_S)  return {1'b1, MAX_S[W-1:0]};
      else                 return {1'b0, v[W-1:0]};
`endif
   endfunction

   logic signed [SW-1:0] sum_p1;
   logic [W:0]           fix_p1;

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : gen_gate
         gate_dir_fsm u_fsm (
            .clk        (clk),
            .reset      (reset),
            .a          (a[g]),
            .b          (b[g]),
            .enter_tick (enter_tick[g]),
            .exit_tick  (exit_tick[g])
         );
      end
   endgenerate

   // Stage p1: net all entries and exits, then clamp or wrap into range
   always_comb begin
      sum_p1 = $signed({{(SW-W){1'b0}}, count}) + popcnt(enter_tick) - popcnt(exit_tick);
      fix_p1 = range_fix(sum_p1);
   end

   // Count, flags and err register together so they change on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         err   <= 1'b0;
      end else begin
         count <= fix_p1[W-1:0];
         full  <= (fix_p1[W-1:0] == W'(MAX));
         empty <= (fix_p1[W-1:0] == '0);
         err   <= fix_p1[W];
      end
   end

endmodule
